line_writeback_buffer: RTL and testbench
========================================

# line_writeback_buffer

Write-back buffer between the data cache and the backing data block RAM. It queues dirty lines evicted by the cache and drains them to RAM one line per cycle, whenever the cache is not using the RAM port for a refill. Evictions cost the cache no RAM write cycle. A refill whose line is still queued gets the newest queued copy through a forwarding lookup. Repeated evictions of the same line coalesce in place.

## Interface
Parameters:
- LINE_BITS, 128, cache line width (words per line × 32)
- LINE_ADDR_BITS, 10, line address width (byte address bits above the line offset)
- DEPTH, 4, number of entries; power of two, ≥ 2

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- evict_valid  in  1  cache presents an evicted dirty line this cycle
- evict_addr  in  LINE_ADDR_BITS  line address of evicted line
- evict_data  in  LINE_BITS  evicted line contents
- evict_ready  out  1  buffer can accept (= !full)
- lookup_addr  in  LINE_ADDR_BITS  line address the cache is about to refill
- lookup_hit  out  1  combinational: a valid entry holds lookup_addr
- lookup_data  out  LINE_BITS  combinational: data of matching entry, 0 when no hit
- mem_busy  in  1  cache uses the RAM port this cycle; buffer must not drain
- mem_we  out  1  combinational: RAM write strobe
- mem_addr  out  LINE_ADDR_BITS  RAM line address (head entry)
- mem_wdata  out  LINE_BITS  RAM write data (head entry)
- count  out  log2(DEPTH)+1  number of valid entries
- empty  out  1  count == 0

## Operation
- Storage: circular FIFO of DEPTH entries {valid, addr, data}, with head/tail pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- Drain: mem_we = !empty & !mem_busy & !reset. mem_addr/mem_wdata are the head entry (0 when empty). When mem_we = 1, the RAM writes at the edge, the head is invalidated and head increments.
- Accept: occurs when evict_valid & evict_ready.
  - Coalesce: if a valid entry other than the one draining this cycle has addr == evict_addr, overwrite its data in place. count and tail are unchanged.
  - Otherwise: write to tail, set valid, increment tail.
  - If the only matching entry is the head being drained this cycle, enqueue a new entry at tail.
- evict_ready depends only on full (count == DEPTH). It does not account for a same-cycle drain. evict_valid while !evict_ready is ignored; the cache holds the line.
- Lookup: compare lookup_addr against all valid entries. Several matches cannot occur because of coalescing. Lookup sees only state registered before the current edge.
- count update per edge: +1 (enqueue only), −1 (drain only), 0 (both, neither, or coalesce + drain → −1).
- Reset: head = tail = 0, count = 0, all valid cleared. During the reset cycle, evict and drain are suppressed and mem_we = 0.

## Timing
- Reset values: evict_ready = 1, lookup_hit = 0, lookup_data = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, count = 0, empty = 1.
- An accepted line is visible to lookup and drain from the next cycle. Minimum eviction-to-RAM latency is 1 cycle after acceptance.
- Throughput: 1 enqueue and 1 drain per cycle when !mem_busy. Full and draining: evict_ready stays 0 that cycle and rises the cycle after.
- mem_busy high holds the queue. Entries stay valid and forwardable indefinitely.
- Reset asserted mid-drain: no write occurs in that cycle. All entries are discarded.

## Test plan
- Reset, then evict A=0x010 data D1, mem_busy=0: next cycle mem_we=1, mem_addr=0x010, mem_wdata=D1; following cycle empty=1, count=0.
- mem_busy=1, evict 0x001..0x004 on consecutive cycles: count reaches 4, evict_ready=0, a 5th eviction is ignored. Release mem_busy: writes appear in order 0x001..0x004, one per cycle, and evict_ready=1 after the first drain.
- mem_busy=1, evict 0x020/D1 then 0x020/D2: count=1, lookup_addr=0x020 gives hit=1, data=D2. Release: a single RAM write with D2.
- Full queue, mem_busy=0, evict_valid=1: the head drains, the eviction is not accepted, evict_ready=1 next cycle, and the retry is accepted with count back to 4.
- Head 0x030 draining while evict 0x030/D3 arrives the same cycle: D_old is written to RAM, D3 is enqueued as a new entry and written to RAM next cycle.
- count=3 with mem_busy=1, assert reset one cycle: count=0, empty=1, lookup_hit=0 for all prior addresses, and no mem_we pulse occurs.

Source files
------------

// File: rtl/line_writeback_buffer.sv
// Write-back buffer: queues evicted dirty lines, coalesces repeat evictions,
// forwards queued data to refills and drains one line per idle RAM cycle.
module line_writeback_buffer #(
    parameter int unsigned LINE_BITS      = 128,
    parameter int unsigned LINE_ADDR_BITS = 10,
    parameter int unsigned DEPTH          = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        evict_valid,
    input  logic [LINE_ADDR_BITS-1:0]   evict_addr,
    input  logic [LINE_BITS-1:0]        evict_data,
    output logic                        evict_ready,
    input  logic [LINE_ADDR_BITS-1:0]   lookup_addr,
    output logic                        lookup_hit,
    output logic [LINE_BITS-1:0]        lookup_data,
    input  logic                        mem_busy,
    output logic                        mem_we,
    output logic [LINE_ADDR_BITS-1:0]   mem_addr,
    output logic [LINE_BITS-1:0]        mem_wdata,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]          valid_q, valid_d;
    logic [LINE_ADDR_BITS-1:0] addr_q [DEPTH];
    logic [LINE_ADDR_BITS-1:0] addr_d [DEPTH];
    logic [LINE_BITS-1:0]      data_q [DEPTH];
    logic [LINE_BITS-1:0]      data_d [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d;
    logic [PTR_W-1:0]          tail_q, tail_d;
    logic [CNT_W-1:0]          count_q, count_d;

    logic             full;
    logic             drain;
    logic             accept;
    logic             enqueue;
    logic             coal_hit;
    logic [PTR_W-1:0] coal_idx;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign evict_ready = !full;
    assign drain       = !empty && !mem_busy && !reset;
    assign accept      = evict_valid && evict_ready && !reset;
    assign enqueue     = accept && !coal_hit;

    assign mem_we    = drain;
    assign mem_addr  = empty ? '0 : addr_q[head_q];
    assign mem_wdata = empty ? '0 : data_q[head_q];

    // Coalesce target: a valid copy of evict_addr that is not leaving this cycle.
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == evict_addr
                && !(drain && PTR_W'(i) == head_q)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    // Forwarding lookup; coalescing guarantees at most one match.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i] == lookup_addr) begin
                lookup_hit  = 1'b1;
                lookup_data = lookup_data | data_q[i];
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CNT_W'(enqueue) - CNT_W'(drain);

        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end

        if (accept) begin
            if (coal_hit) begin
                data_d[coal_idx] = evict_data;
            end else begin
                valid_d[tail_q] = 1'b1;
                addr_d[tail_q]  = evict_addr;
                data_d[tail_q]  = evict_data;
                tail_d          = tail_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= addr_d[i];
            data_q[i] <= data_d[i];
        end
    end

endmodule

// File: tb/tb_line_writeback_buffer.sv
// Randomized and directed bench for line_writeback_buffer against a queue model.
module tb_line_writeback_buffer;

    localparam int unsigned LB    = 128;
    localparam int unsigned AB    = 10;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          evict_valid;
    logic [AB-1:0] evict_addr;
    logic [LB-1:0] evict_data;
    logic          evict_ready;
    logic [AB-1:0] lookup_addr;
    logic          lookup_hit;
    logic [LB-1:0] lookup_data;
    logic          mem_busy;
    logic          mem_we;
    logic [AB-1:0] mem_addr;
    logic [LB-1:0] mem_wdata;
    logic [CW-1:0] count;
    logic          empty;

    always #5 clk = ~clk;

    line_writeback_buffer #(
        .LINE_BITS(LB), .LINE_ADDR_BITS(AB), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .evict_valid(evict_valid), .evict_addr(evict_addr), .evict_data(evict_data),
        .evict_ready(evict_ready),
        .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .mem_busy(mem_busy), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .empty(empty)
    );

    typedef struct {
        logic [AB-1:0] a;
        logic [LB-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input logic [AB-1:0] a);
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].a == a) return i;
        return -1;
    endfunction

    // Check outputs against the queue model, then advance the model across the edge.
    task automatic tick();
        int    li;
        logic  exp_we;
        logic  acc;
        ent_t  e;
        #1;
        li     = find(lookup_addr);
        exp_we = (mq.size() != 0) && !mem_busy && !reset;
        check("evict_ready", LB'(evict_ready), LB'(mq.size() < DEPTH));
        check("empty",       LB'(empty),       LB'(mq.size() == 0));
        check("count",       LB'(count),       LB'(mq.size()));
        check("mem_we",      LB'(mem_we),      LB'(exp_we));
        check("mem_addr",    LB'(mem_addr),    (mq.size() != 0) ? LB'(mq[0].a) : '0);
        check("mem_wdata",   mem_wdata,        (mq.size() != 0) ? mq[0].d : '0);
        check("lookup_hit",  LB'(lookup_hit),  LB'(li >= 0));
        check("lookup_data", lookup_data,      (li >= 0) ? mq[li].d : '0);

        if (reset) begin
            mq.delete();
        end else begin
            acc = evict_valid && (mq.size() < DEPTH);
            if (exp_we) void'(mq.pop_front());
            if (acc) begin
                li = find(evict_addr);
                if (li >= 0) begin
                    e      = mq[li];
                    e.d    = evict_data;
                    mq[li] = e;
                end else begin
                    e.a = evict_addr;
                    e.d = evict_data;
                    mq.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [AB-1:0] a, input logic [LB-1:0] d,
                         input logic busy, input logic rst, input logic [AB-1:0] la);
        evict_valid = v;
        evict_addr  = a;
        evict_data  = d;
        mem_busy    = busy;
        reset       = rst;
        lookup_addr = la;
        tick();
    endtask

    function automatic logic [LB-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    logic [LB-1:0] d1, d2, d3;

    initial begin
        reset = 1'b1; evict_valid = 1'b0; evict_addr = '0; evict_data = '0;
        mem_busy = 1'b0; lookup_addr = '0;
        @(posedge clk);
        @(negedge clk);
        drive(0, '0, '0, 0, 1, 10'h010);
        drive(0, '0, '0, 0, 1, 10'h010);

        // Single eviction reaches RAM the following cycle.
        d1 = rnd_line();
        drive(1, 10'h010, d1, 0, 0, 10'h010);
        drive(0, '0, '0, 0, 0, 10'h010);
        drive(0, '0, '0, 0, 0, 10'h010);

        // Fill while busy, fifth eviction ignored, then in-order drain.
        for (int i = 1; i <= 5; i++) drive(1, AB'(i), rnd_line(), 1, 0, AB'(i));
        for (int i = 0; i < 6; i++) drive(0, '0, '0, 0, 0, AB'(i));

        // Coalescing keeps one entry holding the newest data.
        d1 = rnd_line(); d2 = rnd_line();
        drive(1, 10'h020, d1, 1, 0, 10'h020);
        drive(1, 10'h020, d2, 1, 0, 10'h020);
        drive(0, '0, '0, 1, 0, 10'h020);
        for (int i = 0; i < 3; i++) drive(0, '0, '0, 0, 0, 10'h020);

        // Full and draining: eviction refused, retry accepted next cycle.
        for (int i = 0; i < 4; i++) drive(1, AB'(10'h040 + i), rnd_line(), 1, 0, '0);
        d3 = rnd_line();
        drive(1, 10'h055, d3, 0, 0, 10'h055);
        drive(1, 10'h055, d3, 1, 0, 10'h055);
        for (int i = 0; i < 6; i++) drive(0, '0, '0, 0, 0, 10'h055);

        // Same-address eviction while that head drains becomes a new entry.
        d1 = rnd_line(); d3 = rnd_line();
        drive(1, 10'h030, d1, 1, 0, 10'h030);
        drive(1, 10'h030, d3, 0, 0, 10'h030);
        drive(0, '0, '0, 0, 0, 10'h030);
        drive(0, '0, '0, 0, 0, 10'h030);

        // Reset with three queued lines discards them without any write.
        for (int i = 0; i < 3; i++) drive(1, AB'(10'h060 + i), rnd_line(), 1, 0, '0);
        drive(0, '0, '0, 0, 1, 10'h060);
        for (int i = 0; i < 3; i++) drive(0, '0, '0, 0, 0, AB'(10'h060 + i));

        // Random traffic on a small address pool to exercise coalescing and forwarding.
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)),
                  AB'($urandom_range(0, 7)),
                  rnd_line(),
                  1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 99) == 0),
                  AB'($urandom_range(0, 8)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
